// File: rtl/uart_core_param.sv
// Full-duplex UART core: TX serialiser with valid/ready handshake and RX deserialiser with
// mid-bit sampling, glitch rejection and framing-error pulse. Define UART_PARITY_EN for even parity.
module uart_core_param #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic              clk_sis,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx,
    input  logic              rx,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_frame_err
`ifdef UART_PARITY_EN
    ,
    output logic              rx_parity_err
`endif
);

    localparam int unsigned TCW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IW  = $clog2(DATA_W + 1);

    localparam logic [TCW-1:0] CntLast  = TCW'(CLKS_PER_BIT - 1);
    localparam logic [TCW-1:0] CntHalf  = TCW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IW-1:0]  IdxLast  = IW'(DATA_W - 1);
    localparam logic [IW-1:0]  StopLast = IW'(STOP_BITS - 1);

    typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop, RxWaitIdle} rx_state_e;

    // ---------------------------------------------------------------- TX
    tx_state_e         tx_state_q, tx_state_d;
    logic [TCW-1:0]    tx_cnt_q, tx_cnt_d;
    logic [IW-1:0]     tx_idx_q, tx_idx_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic              tx_q, tx_d;
    logic              init_q;
    logic              tx_bit_end;
`ifdef UART_PARITY_EN
    logic              tx_par_q, tx_par_d;
`endif

    assign tx_bit_end = (tx_cnt_q == CntLast);
    // Held low through reset and the reset edge itself so tx_ready rises one edge after release.
    assign tx_ready   = init_q && (tx_state_q == TxIdle);
    assign tx         = tx_q;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
`ifdef UART_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        if (tx_state_q != TxIdle) begin
            tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + TCW'(1);
        end
        case (tx_state_q)
            TxIdle: begin
                if (tx_valid && tx_ready) begin
                    tx_shift_d = tx_data;
`ifdef UART_PARITY_EN
                    tx_par_d   = ^tx_data;
`endif
                    tx_cnt_d   = '0;
                    tx_idx_d   = '0;
                    tx_state_d = TxStart;
                end
            end
            TxStart: begin
                if (tx_bit_end) begin
                    tx_state_d = TxData;
                end
            end
            TxData: begin
                if (tx_bit_end) begin
                    tx_shift_d = tx_shift_q >> 1;
                    if (tx_idx_q == IdxLast) begin
                        tx_idx_d = '0;
`ifdef UART_PARITY_EN
                        tx_state_d = TxParity;
`else
                        tx_state_d = TxStop;
`endif
                    end else begin
                        tx_idx_d = tx_idx_q + IW'(1);
                    end
                end
            end
            TxParity: begin
                if (tx_bit_end) begin
                    tx_state_d = TxStop;
                end
            end
            TxStop: begin
                if (tx_bit_end) begin
                    if (tx_idx_q == StopLast) begin
                        tx_idx_d   = '0;
                        tx_state_d = TxIdle;
                    end else begin
                        tx_idx_d = tx_idx_q + IW'(1);
                    end
                end
            end
            default: tx_state_d = TxIdle;
        endcase

        // Line level is registered from the next state so tx never glitches.
        case (tx_state_d)
            TxStart:  tx_d = 1'b0;
            TxData:   tx_d = tx_shift_d[0];
`ifdef UART_PARITY_EN
            TxParity: tx_d = tx_par_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_sis) begin
        if (!rst) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
            init_q     <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
            init_q     <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par_q   <= tx_par_d;
`endif
        end
    end

    // ---------------------------------------------------------------- RX
    rx_state_e         rx_state_q, rx_state_d;
    logic [TCW-1:0]    rx_cnt_q, rx_cnt_d;
    logic [IW-1:0]     rx_idx_q, rx_idx_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              rx_ferr_q, rx_ferr_d;
    logic              rx_meta_q, rxs_q;
    logic              rx_bit_end;
`ifdef UART_PARITY_EN
    logic              rx_par_q, rx_par_d;
    logic              rx_perr_q, rx_perr_d;

    assign rx_parity_err = rx_perr_q;
`endif

    assign rx_bit_end   = (rx_cnt_q == CntLast);
    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign rx_frame_err = rx_ferr_q;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_ferr_d  = 1'b0;
`ifdef UART_PARITY_EN
        rx_par_d   = rx_par_q;
        rx_perr_d  = 1'b0;
`endif
        if (rx_state_q != RxIdle && rx_state_q != RxWaitIdle) begin
            rx_cnt_d = rx_bit_end ? '0 : rx_cnt_q + TCW'(1);
        end
        case (rx_state_q)
            RxIdle: begin
                if (!rxs_q) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RxStart;
                end
            end
            RxStart: begin
                // Half-bit check: a start bit that has already gone high is a glitch.
                if (rx_cnt_q == CntHalf) begin
                    rx_cnt_d   = '0;
                    rx_idx_d   = '0;
                    rx_state_d = rxs_q ? RxIdle : RxData;
                end
            end
            RxData: begin
                if (rx_bit_end) begin
                    rx_shift_d = {rxs_q, rx_shift_q[DATA_W-1:1]};
                    if (rx_idx_q == IdxLast) begin
                        rx_idx_d = '0;
`ifdef UART_PARITY_EN
                        rx_state_d = RxParity;
`else
                        rx_state_d = RxStop;
`endif
                    end else begin
                        rx_idx_d = rx_idx_q + IW'(1);
                    end
                end
            end
            RxParity: begin
                if (rx_bit_end) begin
`ifdef UART_PARITY_EN
                    rx_par_d   = rxs_q;
`endif
                    rx_state_d = RxStop;
                end
            end
            RxStop: begin
                if (rx_bit_end) begin
                    if (rxs_q) begin
                        rx_data_d  = rx_shift_q;
                        rx_valid_d = 1'b1;
`ifdef UART_PARITY_EN
                        rx_perr_d  = rx_par_q ^ (^rx_shift_q);
`endif
                        rx_state_d = RxIdle;
                    end else begin
                        rx_ferr_d  = 1'b1;
                        rx_state_d = RxWaitIdle;
                    end
                end
            end
            RxWaitIdle: begin
                if (rxs_q) begin
                    rx_state_d = RxIdle;
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    always_ff @(posedge clk_sis) begin
        if (!rst) begin
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_q   <= 1'b0;
            rx_perr_q  <= 1'b0;
`endif
        end else begin
            rx_meta_q  <= rx;
            rxs_q      <= rx_meta_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_ferr_q  <= rx_ferr_d;
`ifdef UART_PARITY_EN
            rx_par_q   <= rx_par_d;
            rx_perr_q  <= rx_perr_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_core_param.sv
// Self-checking bench for uart_core_param: loopback and bit-banged RX frames against a
// frame-level reference model. Exercises parity too when UART_PARITY_EN is defined.
module tb_uart_core_param;

    localparam int unsigned W = 8;
    localparam int unsigned C = 16;
    localparam int unsigned S = 1;
`ifdef UART_PARITY_EN
    localparam int unsigned PAR = 1;
`else
    localparam int unsigned PAR = 0;
`endif
    localparam int unsigned NB    = 1 + W + PAR + S;
    localparam int unsigned FRAME = NB * C;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         tx;
    logic         rx;
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic         rx_frame_err;
    logic         loop_en;
    logic         rx_drv;
`ifdef UART_PARITY_EN
    logic         rx_parity_err;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int ferr_cnt = 0;
    int perr_cnt = 0;
    int stray_perr = 0;
    logic [W-1:0] rx_log[$];

    assign rx = loop_en ? tx : rx_drv;
    always #5 clk = ~clk;

    uart_core_param #(
        .DATA_W       (W),
        .CLKS_PER_BIT (C),
        .STOP_BITS    (S)
    ) dut (
        .clk_sis      (clk),
        .rst          (rst),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx           (tx),
        .rx           (rx),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err)
`ifdef UART_PARITY_EN
        ,
        .rx_parity_err(rx_parity_err)
`endif
    );

    // Receive monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) rx_log.push_back(rx_data);
        if (rx_frame_err === 1'b1) ferr_cnt++;
`ifdef UART_PARITY_EN
        if (rx_parity_err === 1'b1) begin
            if (rx_valid === 1'b1) perr_cnt++;
            else stray_perr++;
        end
`endif
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Reference: line level of bit position b in a frame carrying d.
    function automatic logic line_bit(input logic [W-1:0] d, input int b, input bit flip);
        if (b == 0) return 1'b0;
        if (b <= int'(W)) return d[b-1];
        if (PAR == 1 && b == int'(W) + 1) return (^d) ^ flip;
        return 1'b1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (tx_ready !== 1'b1 && n < 2 * int'(FRAME)) begin
            step();
            n++;
        end
        if (tx_ready !== 1'b1) check("tx_ready timeout", tx_ready, 1);
    endtask

    task automatic send_tx(input logic [W-1:0] d, input bit chk_line);
        wait_ready();
        tx_data  = d;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        for (int k = 1; k <= int'(FRAME); k++) begin
            if (k > 1) step();
            if (chk_line && k == 1) check("tx_ready low in frame", tx_ready, 0);
            if (chk_line && ((k - 1) % int'(C)) == int'(C / 2))
                check($sformatf("tx bit %0d of 0x%02h", (k - 1) / int'(C), d), tx,
                      line_bit(d, (k - 1) / int'(C), 1'b0));
        end
        step();
        if (chk_line) check("tx_ready after frame", tx_ready, 1);
    endtask

    task automatic drive_frame(input logic [W-1:0] d, input logic stop_val, input bit flip);
        loop_en = 1'b0;
        for (int b = 0; b < int'(NB); b++) begin
            rx_drv = (b >= int'(1 + W + PAR)) ? stop_val : line_bit(d, b, flip);
            repeat (C) step();
        end
    endtask

    task automatic expect_rx(input logic [W-1:0] d);
        repeat (3) step();
        check("rx_valid count", rx_log.size(), 1);
        if (rx_log.size() > 0) check("rx_data", rx_log[0], d);
        rx_log.delete();
    endtask

    initial begin
        int n;
        int ferr0;
        logic [W-1:0] d;

        rst = 1'b0; tx_valid = 1'b0; tx_data = '0; loop_en = 1'b1; rx_drv = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset tx", tx, 1);
        check("reset tx_ready", tx_ready, 0);
        check("reset rx_data", rx_data, 0);
        check("reset rx_valid", rx_valid, 0);
        check("reset rx_frame_err", rx_frame_err, 0);
        rst = 1'b1;
        step();
        check("tx_ready after reset", tx_ready, 1);

        // Loopback 0xA5 with full line check.
        send_tx(8'hA5, 1'b1);
        expect_rx(8'hA5);

        // Back-to-back: tx_valid held across two words.
        tx_data = 8'h00; tx_valid = 1'b1;
        step();
        tx_data = 8'hFF;
        n = 0;
        while (tx_ready !== 1'b1 && n < 2 * int'(FRAME)) begin
            step();
            n++;
        end
        check("b2b ready cycle", n, FRAME);
        step();
        check("b2b start no gap", tx, 0);
        check("b2b tx_ready low", tx_ready, 0);
        tx_valid = 1'b0;
        repeat (FRAME + 4) step();
        check("b2b rx count", rx_log.size(), 2);
        if (rx_log.size() == 2) begin
            check("b2b rx first", rx_log[0], 8'h00);
            check("b2b rx second", rx_log[1], 8'hFF);
        end
        rx_log.delete();

        // Short low glitch must be ignored.
        loop_en = 1'b0; rx_drv = 1'b0;
        repeat (4) step();
        rx_drv = 1'b1;
        repeat (3 * C) step();
        check("glitch rx_valid", rx_log.size(), 0);
        check("glitch frame_err", ferr_cnt, 0);
        drive_frame(8'h3C, 1'b1, 1'b0);
        rx_drv = 1'b1;
        repeat (C) step();
        expect_rx(8'h3C);

        // Framing error followed by a break, then recovery.
        drive_frame(8'h5A, 1'b0, 1'b0);
        repeat (3 * C) step();
        rx_drv = 1'b1;
        repeat (2 * C) step();
        check("ferr pulse count", ferr_cnt, 1);
        check("ferr no rx_valid", rx_log.size(), 0);
        check("ferr rx_data held", rx_data, 8'h3C);
        drive_frame(8'h81, 1'b1, 1'b0);
        rx_drv = 1'b1;
        repeat (C) step();
        expect_rx(8'h81);

        // Reset 50 cycles into a TX frame.
        loop_en = 1'b1;
        ferr0 = ferr_cnt;
        wait_ready();
        tx_data = 8'h99; tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        repeat (49) step();
        rst = 1'b0;
        step();
        check("mid reset tx", tx, 1);
        check("mid reset tx_ready", tx_ready, 0);
        step();
        rst = 1'b1;
        step();
        check("tx_ready after mid reset", tx_ready, 1);
        repeat (FRAME) step();
        check("mid reset no rx_valid", rx_log.size(), 0);
        check("mid reset no frame_err", ferr_cnt, ferr0);
        check("mid reset rx_data", rx_data, 0);
        send_tx(8'h42, 1'b1);
        expect_rx(8'h42);

        // Randomised loopback words.
        for (int i = 0; i < 8; i++) begin
            d = W'($urandom);
            send_tx(d, 1'b1);
            expect_rx(d);
        end

`ifdef UART_PARITY_EN
        send_tx(8'h07, 1'b1);
        expect_rx(8'h07);
        check("parity clean", perr_cnt, 0);
        drive_frame(8'h07, 1'b1, 1'b1);
        rx_drv = 1'b1;
        repeat (C) step();
        expect_rx(8'h07);
        check("parity err with valid", perr_cnt, 1);
        check("parity err stray", stray_perr, 0);
        loop_en = 1'b1;
`endif

        check("final frame_err count", ferr_cnt, 1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
        $fatal(1);
    end

endmodule
